// File: rtl/dsp_mac_sequencer_if.sv
// ----------------------------------------------------------------------------
// dsp_mac_sequencer_if
// Purpose : Bundles the sample stream, the result stream and the dsp48a1
//           control/data ports of the MAC sequencer.
// Modports: slave  - the sequencer (consumes samples, drives slice controls)
//           master - the environment (stream source, result sink, slice)
// Signals : IN_VALID/IN_READY/IN_A/IN_B/IN_LAST[/IN_SUB]  sample stream
//           RES_VALID/RES_READY/RES_DATA/RES_CNT          result stream
//           DSP_A/B/OPMODE/CEA/CEB/CEM/CEP/CEOPMODE/P     slice side
// Config  : DSP_SEQ_SUB_EN adds IN_SUB (per-sample subtract).
// ----------------------------------------------------------------------------
interface dsp_mac_sequencer_if #(
    parameter int DATA_W = 18,
    parameter int P_W    = 48,
    parameter int CNT_W  = 16
);
    logic              IN_VALID;
    logic              IN_READY;
    logic [DATA_W-1:0] IN_A;
    logic [DATA_W-1:0] IN_B;
    logic              IN_LAST;
`ifdef DSP_SEQ_SUB_EN
    logic              IN_SUB;
`endif
    logic              RES_VALID;
    logic              RES_READY;
    logic [P_W-1:0]    RES_DATA;
    logic [CNT_W-1:0]  RES_CNT;
    logic [DATA_W-1:0] DSP_A;
    logic [DATA_W-1:0] DSP_B;
    logic [7:0]        DSP_OPMODE;
    logic              DSP_CEA;
    logic              DSP_CEB;
    logic              DSP_CEM;
    logic              DSP_CEP;
    logic              DSP_CEOPMODE;
    logic [P_W-1:0]    DSP_P;

    modport slave (
`ifdef DSP_SEQ_SUB_EN
        input  IN_SUB,
`endif
        input  IN_VALID, IN_A, IN_B, IN_LAST, RES_READY, DSP_P,
        output IN_READY, RES_VALID, RES_DATA, RES_CNT,
        output DSP_A, DSP_B, DSP_OPMODE,
        output DSP_CEA, DSP_CEB, DSP_CEM, DSP_CEP, DSP_CEOPMODE
    );

    modport master (
`ifdef DSP_SEQ_SUB_EN
        output IN_SUB,
`endif
        output IN_VALID, IN_A, IN_B, IN_LAST, RES_READY, DSP_P,
        input  IN_READY, RES_VALID, RES_DATA, RES_CNT,
        input  DSP_A, DSP_B, DSP_OPMODE,
        input  DSP_CEA, DSP_CEB, DSP_CEM, DSP_CEP, DSP_CEOPMODE
    );
endinterface

// File: rtl/dsp_mac_sequencer.sv
// ----------------------------------------------------------------------------
// dsp_mac_sequencer
// Purpose : Frame-based multiply-accumulate controller for one dsp48a1 slice
//           (A1REG=B1REG=MREG=PREG=OPMODEREG=1). Each accepted (A,B) pair is
//           steered through the slice pipeline by clock enables; the frame
//           sum sum(A*B) is returned once the last product lands in P.
// Ports   : CLK    - clock shared with the slice
//           RST_N  - asynchronous active-low reset
//           bus    - dsp_mac_sequencer_if.slave (sample stream, result
//                    stream, slice A/B/OPMODE/CE outputs, slice P input)
// Config  : DSP_SEQ_SUB_EN - per-sample IN_SUB selects P = Z - M.
// ----------------------------------------------------------------------------
module dsp_mac_sequencer #(
    parameter int DATA_W = 18,
    parameter int P_W    = 48,
    parameter int CNT_W  = 16
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    dsp_mac_sequencer_if.slave     bus
);
    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_DONE} state_t;

    state_t           r_state;
    logic             r_cem;        // tag stage 1 valid: product enters M
    logic             r_cep;        // tag stage 2 valid: P loads
    logic             r_s1_last;
    logic             r_s2_last;
    logic [7:0]       r_opmode;
    logic             r_res_valid;
    logic [CNT_W-1:0] r_cnt;

    logic              w_ready;
    logic              w_accept;
    logic              w_first;
    logic              w_sub;
    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;
    logic [P_W-1:0]    w_p;

    // Gated by reset so nothing is accepted while the block is held in reset.
    assign w_ready  = RST_N & ((r_state == S_IDLE) | (r_state == S_ACCUM));
    assign w_accept = bus.IN_VALID & w_ready;
    assign w_first  = (r_state == S_IDLE);
`ifdef DSP_SEQ_SUB_EN
    assign w_sub    = bus.IN_SUB;
`else
    assign w_sub    = 1'b0;
`endif

    // A/B go straight to the slice; A1/B1 registers capture them on CEA/CEB.
    assign w_a = bus.IN_A;
    assign w_b = bus.IN_B;
    assign w_p = bus.DSP_P;

    assign bus.IN_READY     = w_ready;
    assign bus.DSP_A        = w_a;
    assign bus.DSP_B        = w_b;
    assign bus.DSP_CEA      = w_accept;
    assign bus.DSP_CEB      = w_accept;
    assign bus.DSP_CEM      = r_cem;
    assign bus.DSP_CEOPMODE = r_cem;
    assign bus.DSP_CEP      = r_cep;
    assign bus.DSP_OPMODE   = r_opmode;
    assign bus.RES_VALID    = r_res_valid;
    assign bus.RES_DATA     = w_p;   // P is frozen in DONE since CEP stays low
    assign bus.RES_CNT      = r_cnt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state     <= S_IDLE;
            r_cem       <= 1'b0;
            r_cep       <= 1'b0;
            r_s1_last   <= 1'b0;
            r_s2_last   <= 1'b0;
            r_opmode    <= 8'h00;
            r_res_valid <= 1'b0;
            r_cnt       <= '0;
        end else begin
            // Tag shift: stage 1 lines up with M/OPMODE regs, stage 2 with P.
            r_cem     <= w_accept;
            r_s1_last <= w_accept & bus.IN_LAST;
            r_cep     <= r_cem;
            r_s2_last <= r_s1_last;

            // X=M always; Z=0 on the first sample (discards stale P), Z=P after.
            // Bit7 turns the post-adder into Z - (X).
            if (w_accept)
                r_opmode <= {w_sub, 3'b000, ~w_first, 3'b001};
            else
                r_opmode <= 8'h00;

            if (w_accept) begin
                if (w_first)
                    r_cnt <= CNT_W'(1);
                else if (r_cnt != {CNT_W{1'b1}})
                    r_cnt <= r_cnt + CNT_W'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (w_accept)
                        r_state <= bus.IN_LAST ? S_DRAIN : S_ACCUM;
                end
                S_ACCUM: begin
                    if (w_accept && bus.IN_LAST)
                        r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    // Last product is loading into P this cycle; valid next.
                    if (r_s2_last) begin
                        r_state     <= S_DONE;
                        r_res_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.RES_READY) begin
                        r_state     <= S_IDLE;
                        r_res_valid <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// ----------------------------------------------------------------------------
// tb_dsp_mac_sequencer
// Bench for dsp_mac_sequencer with a behavioural dsp48a1 slice model
// (A1/B1, M, OPMODE and P registers, sync resets tied low).
// ----------------------------------------------------------------------------
module tb_dsp_mac_sequencer;
    localparam int DW = 18;
    localparam int PW = 48;
    localparam int CW = 16;

    logic CLK;
    logic RST_N;

    dsp_mac_sequencer_if #(.DATA_W(DW), .P_W(PW), .CNT_W(CW)) bus ();

    dsp_mac_sequencer #(.DATA_W(DW), .P_W(PW), .CNT_W(CW)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // ---------------- slice model ----------------
    logic signed [DW-1:0]   s_a1, s_b1;
    logic signed [2*DW-1:0] s_prod;
    logic signed [PW-1:0]   s_m, s_p, s_x, s_z;
    logic [7:0]             s_op;

    initial begin
        s_a1 = '0; s_b1 = '0; s_m = '0; s_p = '0; s_op = 8'h00;
    end

    assign s_prod = s_a1 * s_b1;
    assign s_x = (s_op[1:0] == 2'b01) ? PW'(s_prod) * 0 + s_m : '0;
    assign s_z = (s_op[3:2] == 2'b10) ? s_p : '0;

    always @(posedge CLK) begin
        if (bus.DSP_CEA) s_a1 <= bus.DSP_A;
        if (bus.DSP_CEB) s_b1 <= bus.DSP_B;
        if (bus.DSP_CEM) s_m  <= PW'(s_prod);
        if (bus.DSP_CEOPMODE) s_op <= bus.DSP_OPMODE;
        if (bus.DSP_CEP) s_p  <= s_op[7] ? (s_z - s_x) : (s_z + s_x);
    end
    assign bus.DSP_P = s_p;

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [PW-1:0] data;
        logic [CW-1:0] cnt;
    } res_t;

    res_t       sb_q[$];
    logic [7:0] op_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    longint     exp_sum;
    int         exp_cnt;
    bit         in_frame = 0;
    int         last_acc_cyc = 0;
    logic       prev_cea = 1'b0;
    logic       prev_cem = 1'b0;

    // Slice alignment: CEM/CEOPMODE one cycle after CEA, CEP one after CEM,
    // and the OPMODE presented with each CEM matches the accepted sample.
    always @(negedge CLK) begin
        #2;
        if (RST_N === 1'b1) begin
            n_cmp++;
            if (bus.DSP_CEM !== prev_cea || bus.DSP_CEOPMODE !== prev_cea || bus.DSP_CEP !== prev_cem) begin
                n_bad++;
                $display("FAIL ce_align: cem=%b ceop=%b cep=%b, required cem=ceop=%b cep=%b",
                         bus.DSP_CEM, bus.DSP_CEOPMODE, bus.DSP_CEP, prev_cea, prev_cem);
            end
            if (bus.DSP_CEM === 1'b1) begin
                n_cmp++;
                if (op_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL opmode_extra: CEM with opmode %h, no sample pending", bus.DSP_OPMODE);
                end else begin
                    logic [7:0] eo;
                    eo = op_q.pop_front();
                    if (bus.DSP_OPMODE !== eo) begin
                        n_bad++;
                        $display("FAIL opmode: got %h, required %h", bus.DSP_OPMODE, eo);
                    end
                end
            end
            prev_cea = bus.DSP_CEA;
            prev_cem = bus.DSP_CEM;
        end else begin
            prev_cea = 1'b0;
            prev_cem = 1'b0;
        end
    end

    // Drive one sample, wait (bounded) for acceptance, update the model.
    task automatic send(input int a, input int b, input bit last, input bit sub, input int gap);
        int w;
        logic [7:0] eop;
        bit first;
        bus.IN_A     = a[DW-1:0];
        bus.IN_B     = b[DW-1:0];
        bus.IN_LAST  = last;
`ifdef DSP_SEQ_SUB_EN
        bus.IN_SUB   = sub;
`endif
        bus.IN_VALID = 1'b1;
        w = 0;
        while (bus.IN_READY !== 1'b1 && w < 50) begin
            @(negedge CLK);
            w++;
        end
        if (w >= 50) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: IN_READY=%b, required 1 within 50 cycles", bus.IN_READY);
        end else begin
            first = !in_frame;
            if (first) begin
                exp_sum = 0;
                exp_cnt = 0;
            end
            if (sub) exp_sum = exp_sum - longint'(a) * longint'(b);
            else     exp_sum = exp_sum + longint'(a) * longint'(b);
            exp_cnt++;
            if (first) eop = sub ? 8'h81 : 8'h01;
            else       eop = sub ? 8'h89 : 8'h09;
            op_q.push_back(eop);
            last_acc_cyc = cyc;
            if (last) begin
                sb_q.push_back('{data: exp_sum[PW-1:0], cnt: exp_cnt[CW-1:0]});
                in_frame = 0;
            end else begin
                in_frame = 1;
            end
        end
        @(negedge CLK);
        bus.IN_VALID = 1'b0;
        bus.IN_LAST  = 1'b0;
        repeat (gap) @(negedge CLK);
    endtask

    // Wait for a result, hold it back for 'hold' cycles, then pop and compare.
    task automatic collect(input int hold, input string name);
        int w;
        logic [PW-1:0] d0;
        logic [CW-1:0] c0;
        res_t e;
        w = 0;
        while (bus.RES_VALID !== 1'b1 && w < 50) begin
            @(negedge CLK);
            w++;
        end
        n_cmp++;
        if (w >= 50) begin
            n_bad++;
            $display("FAIL %s_timeout: RES_VALID=%b, required 1 within 50 cycles", name, bus.RES_VALID);
            return;
        end
        n_cmp++;
        if (cyc - last_acc_cyc != 3) begin
            n_bad++;
            $display("FAIL %s_latency: RES_VALID after %0d cycles, required 3", name, cyc - last_acc_cyc);
        end
        d0 = bus.RES_DATA;
        c0 = bus.RES_CNT;
        repeat (hold) begin
            @(negedge CLK);
            n_cmp++;
            if (bus.RES_VALID !== 1'b1 || bus.RES_DATA !== d0 || bus.RES_CNT !== c0 || bus.IN_READY !== 1'b0) begin
                n_bad++;
                $display("FAIL %s_hold: valid=%b data=%h cnt=%0d in_ready=%b, required 1 %h %0d 0",
                         name, bus.RES_VALID, bus.RES_DATA, bus.RES_CNT, bus.IN_READY, d0, c0);
            end
        end
        bus.RES_READY = 1'b1;
        n_cmp++;
        if (sb_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s_unexpected: result %h with empty scoreboard", name, bus.RES_DATA);
        end else begin
            e = sb_q.pop_front();
            if (bus.RES_DATA !== e.data) begin
                n_bad++;
                $display("FAIL %s_data: got %h, required %h", name, bus.RES_DATA, e.data);
            end
            n_cmp++;
            if (bus.RES_CNT !== e.cnt) begin
                n_bad++;
                $display("FAIL %s_cnt: got %0d, required %0d", name, bus.RES_CNT, e.cnt);
            end
        end
        @(negedge CLK);
        bus.RES_READY = 1'b0;
        n_cmp++;
        if (bus.RES_VALID !== 1'b0 || bus.IN_READY !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_release: valid=%b in_ready=%b, required 0 1", name, bus.RES_VALID, bus.IN_READY);
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        n_cmp++;
        if (bus.IN_READY !== 1'b0 || bus.RES_VALID !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_hs: in_ready=%b res_valid=%b, required 0 0", bus.IN_READY, bus.RES_VALID);
        end
        n_cmp++;
        if (bus.RES_CNT !== '0 || bus.DSP_OPMODE !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_regs: cnt=%0d opmode=%h, required 0 00", bus.RES_CNT, bus.DSP_OPMODE);
        end
        n_cmp++;
        if ({bus.DSP_CEA, bus.DSP_CEB, bus.DSP_CEM, bus.DSP_CEP, bus.DSP_CEOPMODE} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_ce: ce=%b, required 00000",
                     {bus.DSP_CEA, bus.DSP_CEB, bus.DSP_CEM, bus.DSP_CEP, bus.DSP_CEOPMODE});
        end
        RST_N = 1'b1;
        @(negedge CLK);
        n_cmp++;
        if (bus.IN_READY !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_idle_ready: got %b, required 1", bus.IN_READY);
        end
    endtask

    task automatic test_single_frame();
        send(1, 2, 0, 0, 0);
        send(3, 4, 0, 0, 0);
        send(5, 6, 1, 0, 0);
        collect(0, "single");
    endtask

    task automatic test_one_sample();
        send(-7, 9, 1, 0, 0);
        collect(0, "one_sample");
    endtask

    task automatic test_gaps_backpressure();
        send(1, 2, 0, 0, 2);
        send(3, 4, 0, 0, 2);
        send(5, 6, 1, 0, 0);
        collect(5, "gaps_bp");
    endtask

    task automatic test_back_to_back();
        send(2, 2, 1, 0, 0);
        collect(0, "b2b_f1");
        send(3, 3, 0, 0, 0);
        send(1, 1, 1, 0, 0);
        collect(0, "b2b_f2");
    endtask

    task automatic test_reset_mid_frame();
        send(1, 1, 0, 0, 0);
        send(1, 1, 0, 0, 0);
        #4;
        RST_N = 1'b0;
        op_q.delete();
        in_frame = 0;
        @(negedge CLK);
        #4;
        RST_N = 1'b1;
        repeat (8) begin
            @(negedge CLK);
            n_cmp++;
            if (bus.RES_VALID !== 1'b0) begin
                n_bad++;
                $display("FAIL midrst_no_result: RES_VALID=%b, required 0", bus.RES_VALID);
            end
        end
        send(4, 5, 1, 0, 0);
        collect(0, "midrst_next");
    endtask

`ifdef DSP_SEQ_SUB_EN
    task automatic test_sub();
        send(10, 10, 0, 0, 0);
        send(3, 2, 0, 1, 0);
        send(2, 2, 1, 1, 0);
        collect(0, "sub_mix");
        send(5, 5, 1, 1, 0);
        collect(0, "sub_first");
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        RST_N         = 1'b0;
        bus.IN_VALID  = 1'b0;
        bus.IN_A      = '0;
        bus.IN_B      = '0;
        bus.IN_LAST   = 1'b0;
        bus.RES_READY = 1'b0;
`ifdef DSP_SEQ_SUB_EN
        bus.IN_SUB    = 1'b0;
`endif
        @(negedge CLK);
        test_reset();
        test_single_frame();
        test_one_sample();
        test_gaps_backpressure();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef DSP_SEQ_SUB_EN
        test_sub();
`endif
        repeat (4) @(negedge CLK);
        n_cmp++;
        if (sb_q.size() != 0 || op_q.size() != 0) begin
            n_bad++;
            $display("FAIL leftover: results=%0d opmodes=%0d pending, required 0 0", sb_q.size(), op_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
